// File: rtl/tl_a_source_allocator_if.sv
// Request, TileLink A-channel and D-channel signals of the source allocator.
// "slave" is the allocator's view; "master" is its environment (requester plus A queue plus D channel).
interface tl_a_source_allocator_if #(
  parameter int SOURCE_BITS = 2
);
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [1:0]             req_size;
  logic [31:0]            req_address;
  logic [63:0]            req_data;

  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_bits_opcode;
  logic [2:0]             a_bits_param;
  logic [3:0]             a_bits_size;
  logic [SOURCE_BITS-1:0] a_bits_source;
  logic [31:0]            a_bits_address;
  logic [7:0]             a_bits_mask;
  logic [63:0]            a_bits_data;

  logic                   d_valid;
  logic                   d_ready;
  logic [SOURCE_BITS-1:0] d_bits_source;

  modport slave (
    input  req_valid, req_write, req_size, req_address, req_data,
    output req_ready,
    output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
    output a_bits_address, a_bits_mask, a_bits_data,
    input  a_ready,
    input  d_valid, d_bits_source,
    output d_ready
  );

  modport master (
    output req_valid, req_write, req_size, req_address, req_data,
    input  req_ready,
    input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
    input  a_bits_address, a_bits_mask, a_bits_data,
    output a_ready,
    output d_valid, d_bits_source,
    input  d_ready
  );
endinterface

// File: rtl/tl_a_source_allocator.sv
// Turns single-beat read/write requests into TileLink A beats, allocating and retiring source IDs.
// Optional watchdog (err_timeout port) is enabled by defining TL_SRC_ALLOC_TIMEOUT_EN.
module tl_a_source_allocator #(
  parameter int SOURCE_BITS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clock,
  input  logic                   reset,
  tl_a_source_allocator_if.slave bus,
  output logic [SOURCE_BITS:0]   inflight_count,
  output logic                   err_spurious
`ifdef TL_SRC_ALLOC_TIMEOUT_EN
  ,
  output logic                   err_timeout
`endif
);

  localparam int NUM_SOURCES = 1 << SOURCE_BITS;

  function automatic logic [7:0] gen_mask(input logic [1:0] size, input logic [2:0] addr);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01 << addr;
      2'd1:    m = 8'h03 << {addr[2:1], 1'b0};
      2'd2:    m = 8'h0F << {addr[2], 2'b00};
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  logic [NUM_SOURCES-1:0] inflight;
  logic [NUM_SOURCES-1:0] alloc_oh;
  logic [NUM_SOURCES-1:0] retire_oh;
  logic [SOURCE_BITS-1:0] alloc_id;
  logic                   have_free;
  logic                   fire;
  logic                   retire;
  logic                   spurious;
  logic                   ready;

  logic                   vld_p1;
  logic [2:0]             opcode_p1;
  logic [3:0]             size_p1;
  logic [SOURCE_BITS-1:0] source_p1;
  logic [31:0]            address_p1;
  logic [7:0]             mask_p1;
  logic [63:0]            data_p1;

  // Lowest-index free ID; scanning downward lets the last hit win.
  always_comb begin
    alloc_id  = '0;
    have_free = 1'b0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (!inflight[i]) begin
        alloc_id  = SOURCE_BITS'(i);
        have_free = 1'b1;
      end
    end
  end

  assign ready     = reset & have_free & (~vld_p1 | bus.a_ready);
  assign fire      = bus.req_valid & ready;
  assign retire    = bus.d_valid & inflight[bus.d_bits_source];
  assign spurious  = bus.d_valid & ~inflight[bus.d_bits_source];
  assign alloc_oh  = fire   ? (NUM_SOURCES'(1) << alloc_id)          : '0;
  assign retire_oh = retire ? (NUM_SOURCES'(1) << bus.d_bits_source) : '0;

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      inflight_count = inflight_count + (SOURCE_BITS + 1)'(inflight[i]);
    end
  end

  // Allocation and retirement never target the same ID in one cycle: one is free, the other busy.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight     <= '0;
      err_spurious <= 1'b0;
    end else begin
      inflight <= (inflight | alloc_oh) & ~retire_oh;
      if (spurious) err_spurious <= 1'b1;
    end
  end

  // Stage p1: registered A beat, held while the downstream queue stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      opcode_p1  <= '0;
      size_p1    <= '0;
      source_p1  <= '0;
      address_p1 <= '0;
      mask_p1    <= '0;
      data_p1    <= '0;
    end else if (fire) begin
      vld_p1     <= 1'b1;
      opcode_p1  <= bus.req_write ? 3'd0 : 3'd4;
      size_p1    <= {2'b00, bus.req_size};
      source_p1  <= alloc_id;
      address_p1 <= bus.req_address;
      mask_p1    <= gen_mask(bus.req_size, bus.req_address[2:0]);
      data_p1    <= bus.req_write ? bus.req_data : 64'd0;
    end else if (vld_p1 && bus.a_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign bus.req_ready      = ready;
  assign bus.a_valid        = vld_p1;
  assign bus.a_bits_opcode  = opcode_p1;
  assign bus.a_bits_param   = 3'd0;
  assign bus.a_bits_size    = size_p1;
  assign bus.a_bits_source  = source_p1;
  assign bus.a_bits_address = address_p1;
  assign bus.a_bits_mask    = mask_p1;
  assign bus.a_bits_data    = data_p1;
  assign bus.d_ready        = 1'b1;

`ifdef TL_SRC_ALLOC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_cnt;

  // Counter parks at the limit so the sticky flag cannot be missed through wraparound.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (retire || (inflight == '0)) begin
        wd_cnt <= '0;
      end else if (wd_cnt != TW'(TIMEOUT_CYCLES)) begin
        wd_cnt <= wd_cnt + TW'(1);
      end
      if (wd_cnt == TW'(TIMEOUT_CYCLES)) err_timeout <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tl_a_source_allocator.sv
// Randomised scoreboard bench for tl_a_source_allocator with a set-of-busy-IDs reference model.
module tb_tl_a_source_allocator;

  localparam int SB = 2;
  localparam int NS = 1 << SB;

  typedef struct {
    logic [2:0]    opcode;
    logic [3:0]    size;
    logic [SB-1:0] source;
    logic [31:0]   address;
    logic [7:0]    mask;
    logic [63:0]   data;
  } beat_t;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [SB:0]   inflight_count;
  logic          err_spurious;
`ifdef TL_SRC_ALLOC_TIMEOUT_EN
  logic          err_timeout;
`endif

  tl_a_source_allocator_if #(.SOURCE_BITS(SB)) bus ();

  tl_a_source_allocator #(.SOURCE_BITS(SB)) dut (
    .clock          (clock),
    .reset          (reset),
    .bus            (bus),
    .inflight_count (inflight_count),
    .err_spurious   (err_spurious)
`ifdef TL_SRC_ALLOC_TIMEOUT_EN
    ,
    .err_timeout    (err_timeout)
`endif
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];
  bit    busy[NS];
  bit    held;
  bit    err_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte mask from the transfer width and the byte lane it starts on.
  function automatic logic [7:0] exp_mask(input logic [1:0] size, input logic [31:0] addr);
    int bytes;
    int lane;
    bytes = 1 << size;
    lane  = int'(addr[2:0]) & ~(bytes - 1);
    return 8'(((1 << bytes) - 1) << lane);
  endfunction

  // Reference model: evaluates the upcoming clock edge from current inputs and model state.
  always @(negedge clock) begin : model
    int  cnt;
    int  low;
    int  src;
    bit  rdy;
    bit  ret;
    beat_t b;
    if (reset) begin
      cnt = 0;
      low = -1;
      for (int i = 0; i < NS; i++) begin
        if (busy[i]) cnt++;
        else if (low < 0) low = i;
      end
      rdy = (low >= 0) && (!held || bus.a_ready);
      check("a_valid",        64'(bus.a_valid),      64'(held));
      check("req_ready",      64'(bus.req_ready),    64'(rdy));
      check("inflight_count", 64'(inflight_count),   64'(cnt));
      check("err_spurious",   64'(err_spurious),     64'(err_m));
      check("d_ready",        64'(bus.d_ready),      64'd1);
      src = int'(bus.d_bits_source);
      ret = bus.d_valid && busy[src];
      if (bus.d_valid && !busy[src]) err_m = 1'b1;
      if (bus.req_valid && rdy) begin
        b.opcode  = bus.req_write ? 3'd0 : 3'd4;
        b.size    = 4'(bus.req_size);
        b.source  = SB'(low);
        b.address = bus.req_address;
        b.mask    = exp_mask(bus.req_size, bus.req_address);
        b.data    = bus.req_write ? bus.req_data : 64'd0;
        sb.push_back(b);
        busy[low] = 1'b1;
        held      = 1'b1;
      end else if (held && bus.a_ready) begin
        held = 1'b0;
      end
      if (ret) busy[src] = 1'b0;
    end
  end

  // Monitor: every presented beat must match the oldest outstanding expectation.
  always @(negedge clock) begin : monitor
    beat_t e;
    if (reset && bus.a_valid) begin
      check("beat_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb[0];
        check("a_opcode",  64'(bus.a_bits_opcode),  64'(e.opcode));
        check("a_param",   64'(bus.a_bits_param),   64'd0);
        check("a_size",    64'(bus.a_bits_size),    64'(e.size));
        check("a_source",  64'(bus.a_bits_source),  64'(e.source));
        check("a_address", 64'(bus.a_bits_address), 64'(e.address));
        check("a_mask",    64'(bus.a_bits_mask),    64'(e.mask));
        check("a_data",    bus.a_bits_data,         e.data);
        if (bus.a_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input bit w, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [63:0] data, input bit ar, input bit dv, input logic [SB-1:0] ds);
    bus.req_valid     = v;
    bus.req_write     = w;
    bus.req_size      = sz;
    bus.req_address   = addr;
    bus.req_data      = data;
    bus.a_ready       = ar;
    bus.d_valid       = dv;
    bus.d_bits_source = ds;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NS; i++) busy[i] = 1'b0;
    held  = 1'b0;
    err_m = 1'b0;
    sb.delete();
  endtask

  task automatic check_reset_state();
    check("rst_a_valid",   64'(bus.a_valid),        64'd0);
    check("rst_req_ready", 64'(bus.req_ready),      64'd0);
    check("rst_count",     64'(inflight_count),     64'd0);
    check("rst_err",       64'(err_spurious),       64'd0);
    check("rst_opcode",    64'(bus.a_bits_opcode),  64'd0);
    check("rst_size",      64'(bus.a_bits_size),    64'd0);
    check("rst_source",    64'(bus.a_bits_source),  64'd0);
    check("rst_address",   64'(bus.a_bits_address), 64'd0);
    check("rst_mask",      64'(bus.a_bits_mask),    64'd0);
    check("rst_data",      bus.a_bits_data,         64'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;
    clear_model();
    bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_address = 0;
    bus.req_data = 0; bus.a_ready = 1; bus.d_valid = 0; bus.d_bits_source = 0;
    #12;
    check_reset_state();
    @(posedge clock); #1;
    reset = 1'b1;

    // Directed: write, read and partial-width masks filling all four IDs.
    drive(1, 1, 2'd3, 32'h0000_1000, 64'hDEAD_BEEF_CAFE_F00D, 1, 0, 0);
    drive(1, 0, 2'd0, 32'h0000_2005, 64'h1111_2222_3333_4444, 1, 0, 0);
    drive(1, 1, 2'd1, 32'h0000_3006, 64'h0123_4567_89AB_CDEF, 1, 0, 0);
    drive(1, 1, 2'd2, 32'h0000_4004, 64'hFEDC_BA98_7654_3210, 1, 0, 0);
    drive(1, 1, 2'd3, 32'h0000_5000, 64'h5555_5555_5555_5555, 1, 0, 0);
    drive(1, 1, 2'd3, 32'h0000_5000, 64'h5555_5555_5555_5555, 1, 1, 2'd2);
    drive(1, 0, 2'd3, 32'h0000_6008, 64'h0, 1, 0, 0);
    drive(0, 0, 2'd0, 32'h0, 64'h0, 1, 1, 2'd0);
    drive(0, 0, 2'd0, 32'h0, 64'h0, 1, 1, 2'd1);
    drive(0, 0, 2'd0, 32'h0, 64'h0, 1, 1, 2'd3);
    drive(0, 0, 2'd0, 32'h0, 64'h0, 1, 1, 2'd2);

    // Downstream stall then back-to-back release.
    drive(1, 1, 2'd3, 32'h0000_7000, 64'hA5A5_A5A5_A5A5_A5A5, 0, 0, 0);
    repeat (3) drive(1, 1, 2'd3, 32'h0000_7100, 64'h5A5A_5A5A_5A5A_5A5A, 0, 0, 0);
    drive(1, 1, 2'd2, 32'h0000_7200, 64'h1, 1, 0, 0);
    drive(1, 0, 2'd1, 32'h0000_7302, 64'h2, 1, 0, 0);
    drive(1, 1, 2'd0, 32'h0000_7407, 64'h3, 1, 0, 0);
    for (int i = 0; i < NS; i++) drive(0, 0, 2'd0, 32'h0, 64'h0, 1, 1, SB'(i));

    // Spurious response for an unallocated ID, then confirm it stays set.
    drive(0, 0, 2'd0, 32'h0, 64'h0, 1, 1, 2'd3);
    repeat (2) drive(0, 0, 2'd0, 32'h0, 64'h0, 1, 0, 0);

    // Randomised traffic with an asynchronous reset pulse in the middle.
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        drive(1, 1, 2'd3, 32'h0000_8000, 64'h77, 1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_a_valid", 64'(bus.a_valid),    64'd0);
        check("mid_count",   64'(inflight_count), 64'd0);
        check("mid_err",     64'(err_spurious),   64'd0);
        clear_model();
        @(posedge clock); #1;
        reset = 1'b1;
      end
      sz   = 2'($urandom_range(0, 3));
      addr = $urandom & ~((32'd1 << sz) - 32'd1);
      drive(($urandom_range(0, 9) < 6), $urandom_range(0, 1) == 1, sz, addr,
            {$urandom, $urandom}, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 9) < 4), SB'($urandom_range(0, NS - 1)));
    end

    repeat (3) drive(0, 0, 2'd0, 32'h0, 64'h0, 1, 0, 0);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_a_source_allocator.md
Name: tl_a_source_allocator

Overview:
- Upstream neighbour of the 2-entry TileLink A-channel queue; converts a simple single-beat read/write request port into TileLink A-channel beats (opcode, param, size, source, address, mask, data).
- Allocates a free source ID per request and holds one registered output beat.
- Retires the source ID when the matching D-channel response is observed.
- Caps outstanding transactions at 2^SOURCE_BITS.

Parameters:
- SOURCE_BITS, 2, width of the A/D source field; NUM_SOURCES = 2^SOURCE_BITS in-flight IDs.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted this cycle when req_valid&req_ready.
- req_write  in  1  1 = write (PutFullData), 0 = read (Get).
- req_size  in  2  log2 bytes, 0..3.
- req_address  in  32  byte address; must be size-aligned.
- req_data  in  64  write data, byte lanes by address[2:0].
- a_valid  out  1  A beat valid; drives the downstream queue's enq_valid.
- a_ready  in  1  downstream enq_ready.
- a_bits_opcode  out  3  0 = PutFullData, 4 = Get.
- a_bits_param  out  3  always 0.
- a_bits_size  out  4  zero-extended req_size.
- a_bits_source  out  SOURCE_BITS  allocated ID.
- a_bits_address  out  32  req_address.
- a_bits_mask  out  8  generated byte mask.
- a_bits_data  out  64  req_data; 0 for Get.
- d_valid  in  1  D response valid.
- d_ready  out  1  tied 1; responses always sunk.
- d_bits_source  in  SOURCE_BITS  ID being retired.
- inflight_count  out  SOURCE_BITS+1  number of IDs currently allocated.
- err_spurious  out  1  sticky; a D response arrived for a non-allocated ID.

Behaviour:
- Reset (reset=0, async):
  - inflight vector clears to 0, so all IDs are free.
  - Output register invalid: a_valid=0, and all a_bits fields are 0.
  - inflight_count=0, err_spurious=0.
  - req_ready=0 while in reset.
  - Reset asserted mid-transaction drops the held beat and forgets all outstanding IDs.
- Allocation:
  - free = ~inflight. The chosen ID is the lowest-index free bit, combinational.
  - have_free = |free.
- Handshake:
  - req_ready = have_free & (~a_valid | a_ready).
  - On req fire: load the output register with the new beat, set a_valid=1, set inflight[id]=1.
  - On a_valid&a_ready without a new request: a_valid=0 next cycle.
  - Latency from req fire to a_valid is 1 cycle.
  - Full throughput of 1 beat per cycle while IDs are available and a_ready=1.
  - a_bits are stable while a_valid&~a_ready.
- Mask generation:
  - size 3: 0xFF.
  - size 2: 0x0F << (address[2]*4).
  - size 1: 0x03 << (address[2:1]*2).
  - size 0: 0x01 << address[2:0].
  - Get carries the same mask as a write of that size.
  - Misaligned addresses are a protocol violation; the mask is computed from the low address bits regardless, with no check.
- Retirement:
  - d_valid=1 with inflight[d_bits_source]=1 clears that bit next cycle.
  - d_valid=1 with inflight[d_bits_source]=0 sets err_spurious=1, held until reset; inflight is unchanged.
- Simultaneous allocate and retire in the same cycle:
  - Both apply.
  - The retired ID is not reusable until the following cycle, because allocation uses the pre-update free vector.
  - inflight_count is unchanged.
- Boundaries:
  - All NUM_SOURCES IDs in flight: req_ready=0.
  - Retire in cycle N allows req_ready=1 in cycle N+1.
  - inflight_count saturates naturally at NUM_SOURCES.

Optional Feature:
- TL_SRC_ALLOC_TIMEOUT_EN defined:
  - Adds output err_timeout (1 bit, sticky, reset 0).
  - A counter increments every cycle while inflight!=0 and no valid retire occurs.
  - The counter clears on any valid retire, or when inflight==0.
  - err_timeout sets when the counter reaches TIMEOUT_CYCLES.
- Macro undefined: no counter, no err_timeout port.

Test Plan:
- Reset release, then write at size 3, address 0x1000, data 0xDEADBEEF_CAFEF00D, a_ready=1 -> next cycle a_valid=1, opcode 0, size 3, source 0, mask 0xFF, inflight_count 1.
- Read at size 0, address 0x2005 -> opcode 4, mask 0x20, data 0, source = lowest free ID.
- Size 1 at 0x..6 -> mask 0xC0; size 2 at 0x..4 -> mask 0xF0.
- Four back-to-back requests with no D responses -> sources 0,1,2,3 and req_ready=0 on the 5th. d_valid with source 2 -> next cycle req_ready=1 and new beat source 2.
- a_ready=0 for 3 cycles with a_valid=1 -> a_bits stable, req_ready=0. a_ready=1 while req_valid=1 -> back-to-back beats with no bubble.
- d_valid with source 3 when not allocated -> err_spurious=1 sticky. Pulse reset low mid-burst -> a_valid=0, inflight_count=0, err_spurious=0 immediately (asynchronous).
